fpu_ss_result_tx: RTL and testbench

Result-return transmitter of the FPU subsystem. It collects completed instructions from the FPU datapath and the FP load path, each tagged with an `fpu_tag_t`. It writes FP destinations into the FP register file and drives exactly one CV-X-IF result transaction per offloaded instruction back to the core, buffered in a small FIFO. It is the return-direction counterpart of the offload/decode path that consumes `offloaded_data_t`.

---
 rtl/fpu_ss_result_tx.sv | 157 +++++++++++++++
 tb/tb_fpu_ss_result_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_result_tx.sv
// FPU subsystem result-return transmitter: FP register-file write-back plus an in-order X-IF result FIFO.
// Optional accumulated exception flags are enabled by defining FPU_SS_FFLAGS_ACC_EN.
package fpu_ss_result_tx_pkg;
    typedef struct packed {
        logic [4:0] addr;
        logic       rd_is_fp;
        logic [3:0] id;
    } fpu_tag_t;
endpackage

module fpu_ss_result_tx
    import fpu_ss_result_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fpu_res_valid_i,
    output logic        fpu_res_ready_o,
    input  logic [31:0] fpu_res_data_i,
    input  fpu_tag_t    fpu_res_tag_i,
    input  logic [4:0]  fpu_res_status_i,
    input  logic        lsu_res_valid_i,
    output logic        lsu_res_ready_o,
    input  logic [31:0] lsu_res_data_i,
    input  fpu_tag_t    lsu_res_tag_i,
    output logic        fpr_we_o,
    output logic [4:0]  fpr_waddr_o,
    output logic [31:0] fpr_wdata_o,
    output logic        x_result_valid_o,
    input  logic        x_result_ready_i,
    output logic [3:0]  x_result_id_o,
    output logic [31:0] x_result_data_o,
    output logic [4:0]  x_result_rd_o,
    output logic        x_result_we_o,
    output logic [4:0]  fflags_o,
    input  logic        fflags_clr_i,
    output logic        fifo_empty_o
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } entry_t;

    entry_t      mem_r [DEPTH];
    logic [AW:0] wptr_r;
    logic [AW:0] rptr_r;
    logic        empty_s;
    logic        full_s;
    logic        pop_s;
    logic        space_s;
    logic        lsu_acc_s;
    logic        fpu_acc_s;
    logic        push_s;
    fpu_tag_t    sel_tag_s;
    logic [31:0] sel_data_s;
    entry_t      new_entry_s;
    entry_t      head_s;
    logic        fpr_we_r;
    logic [4:0]  fpr_waddr_r;
    logic [31:0] fpr_wdata_r;

    // Occupancy, arbitration (LSU wins) and the entry to be pushed.
    always_comb begin
        empty_s   = (wptr_r == rptr_r);
        full_s    = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
        pop_s     = !empty_s && x_result_ready_i;
        space_s   = !rst_i && (!full_s || pop_s);
        lsu_acc_s = lsu_res_valid_i && space_s;
        fpu_acc_s = fpu_res_valid_i && space_s && !lsu_res_valid_i;
        push_s    = lsu_acc_s || fpu_acc_s;
        if (lsu_res_valid_i) begin
            sel_tag_s  = lsu_res_tag_i;
            sel_data_s = lsu_res_data_i;
        end else begin
            sel_tag_s  = fpu_res_tag_i;
            sel_data_s = fpu_res_data_i;
        end
        new_entry_s.id   = sel_tag_s.id;
        new_entry_s.data = sel_data_s;
        new_entry_s.rd   = sel_tag_s.addr;
        new_entry_s.we   = !sel_tag_s.rd_is_fp;
        head_s           = mem_r[rptr_r[AW-1:0]];
    end

    // Result FIFO storage and pointers; reset also clears storage so the head reads as zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wptr_r[AW-1:0]] <= new_entry_s;
                wptr_r                <= wptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + (AW+1)'(1);
            end
        end
    end

    // FP register-file write, issued the cycle after acceptance independent of FIFO position.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fpr_we_r    <= 1'b0;
            fpr_waddr_r <= 5'd0;
            fpr_wdata_r <= 32'd0;
        end else begin
            fpr_we_r <= push_s && sel_tag_s.rd_is_fp;
            if (push_s && sel_tag_s.rd_is_fp) begin
                fpr_waddr_r <= sel_tag_s.addr;
                fpr_wdata_r <= sel_data_s;
            end
        end
    end

`ifdef FPU_SS_FFLAGS_ACC_EN
    logic [4:0] fflags_r;

    // Sticky exception flags; a clear in the same cycle as an FPU accept keeps only the new status.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fflags_r <= 5'd0;
        end else if (fpu_acc_s) begin
            fflags_r <= (fflags_clr_i ? 5'd0 : fflags_r) | fpu_res_status_i;
        end else if (fflags_clr_i) begin
            fflags_r <= 5'd0;
        end
    end

    assign fflags_o = fflags_r;
`else
    logic unused_flags_s;
    assign unused_flags_s = ^{fpu_res_status_i, fflags_clr_i};
    assign fflags_o       = 5'd0;
`endif

    assign lsu_res_ready_o  = space_s;
    assign fpu_res_ready_o  = space_s && !lsu_res_valid_i;
    assign fpr_we_o         = fpr_we_r;
    assign fpr_waddr_o      = fpr_waddr_r;
    assign fpr_wdata_o      = fpr_wdata_r;
    assign x_result_valid_o = !empty_s;
    assign x_result_id_o    = head_s.id;
    assign x_result_data_o  = head_s.data;
    assign x_result_rd_o    = head_s.rd;
    assign x_result_we_o    = head_s.we;
    assign fifo_empty_o     = empty_s;

endmodule

// File: tb/tb_fpu_ss_result_tx.sv
// Scoreboard bench for fpu_ss_result_tx: directed cases from the plan followed by random traffic,
// checked against a queue-based reference model (follows FPU_SS_FFLAGS_ACC_EN when defined).
module tb_fpu_ss_result_tx;
    import fpu_ss_result_tx_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } fpr_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        fpu_res_valid_i = 1'b0;
    logic        fpu_res_ready_o;
    logic [31:0] fpu_res_data_i = 32'd0;
    fpu_tag_t    fpu_res_tag_i = '0;
    logic [4:0]  fpu_res_status_i = 5'd0;
    logic        lsu_res_valid_i = 1'b0;
    logic        lsu_res_ready_o;
    logic [31:0] lsu_res_data_i = 32'd0;
    fpu_tag_t    lsu_res_tag_i = '0;
    logic        fpr_we_o;
    logic [4:0]  fpr_waddr_o;
    logic [31:0] fpr_wdata_o;
    logic        x_result_valid_o;
    logic        x_result_ready_i = 1'b0;
    logic [3:0]  x_result_id_o;
    logic [31:0] x_result_data_o;
    logic [4:0]  x_result_rd_o;
    logic        x_result_we_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i = 1'b0;
    logic        fifo_empty_o;

    exp_t        sb[$];
    fpr_t        fpr_exp[$];
    logic [4:0]  mflags = 5'd0;
    logic        popped_now = 1'b0;
    logic        prev_rst = 1'b1;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fpu_ss_result_tx #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .fpu_res_valid_i(fpu_res_valid_i), .fpu_res_ready_o(fpu_res_ready_o),
        .fpu_res_data_i(fpu_res_data_i), .fpu_res_tag_i(fpu_res_tag_i),
        .fpu_res_status_i(fpu_res_status_i),
        .lsu_res_valid_i(lsu_res_valid_i), .lsu_res_ready_o(lsu_res_ready_o),
        .lsu_res_data_i(lsu_res_data_i), .lsu_res_tag_i(lsu_res_tag_i),
        .fpr_we_o(fpr_we_o), .fpr_waddr_o(fpr_waddr_o), .fpr_wdata_o(fpr_wdata_o),
        .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
        .x_result_id_o(x_result_id_o), .x_result_data_o(x_result_data_o),
        .x_result_rd_o(x_result_rd_o), .x_result_we_o(x_result_we_o),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i), .fifo_empty_o(fifo_empty_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic fpu_tag_t mk_tag(input logic [4:0] addr, input logic fp, input logic [3:0] id);
        fpu_tag_t t;
        t.addr     = addr;
        t.rd_is_fp = fp;
        t.id       = id;
        return t;
    endfunction

    // Monitor: one sample per cycle, 1 time unit after inputs change, well before the rising edge.
    initial begin
        fpr_t f;
        forever begin
            @(negedge clk);
            #1;
            popped_now = 1'b0;
            if (!rst_i) begin
                check("x_valid", 32'(x_result_valid_o), 32'(sb.size() > 0));
                check("fifo_empty", 32'(fifo_empty_o), 32'(sb.size() == 0));
                if (sb.size() > 0) begin
                    check("x_id", 32'(x_result_id_o), 32'(sb[0].id));
                    check("x_data", x_result_data_o, sb[0].data);
                    check("x_rd", 32'(x_result_rd_o), 32'(sb[0].rd));
                    check("x_we", 32'(x_result_we_o), 32'(sb[0].we));
                    if (x_result_ready_i) begin
                        void'(sb.pop_front());
                        popped_now = 1'b1;
                    end
                end
                check("fpr_we", 32'(fpr_we_o), 32'(fpr_exp.size() > 0));
                if (fpr_exp.size() > 0) begin
                    f = fpr_exp.pop_front();
                    check("fpr_waddr", 32'(fpr_waddr_o), 32'(f.addr));
                    check("fpr_wdata", fpr_wdata_o, f.data);
                end
                check("fflags", 32'(fflags_o), 32'(mflags));
                if (prev_rst) begin
                    check("rst_x_data", x_result_data_o, 32'd0);
                    check("rst_x_id_rd_we", {23'd0, x_result_id_o, x_result_rd_o, x_result_we_o}, 32'd0);
                    check("rst_fpr_addr_data", fpr_wdata_o | 32'(fpr_waddr_o), 32'd0);
                end
            end
            prev_rst = rst_i;
        end
    end

    // One stimulus cycle: drive, check readies against the model, then update the model.
    task automatic drive(input logic lv, input fpu_tag_t lt, input logic [31:0] ld,
                         input logic fv, input fpu_tag_t ft, input logic [31:0] fd,
                         input logic [4:0] st, input logic clr, input logic xr, input logic rst,
                         output logic l_acc, output logic f_acc);
        int   pending;
        logic space;
        exp_t e;
        fpr_t f;
        @(negedge clk);
        lsu_res_valid_i  = lv;  lsu_res_tag_i = lt;  lsu_res_data_i = ld;
        fpu_res_valid_i  = fv;  fpu_res_tag_i = ft;  fpu_res_data_i = fd;
        fpu_res_status_i = st;  fflags_clr_i  = clr;
        x_result_ready_i = xr;  rst_i = rst;
        #2;
        pending = sb.size() + (popped_now ? 1 : 0);
        space   = !rst && ((pending < DEPTH) || (xr && pending > 0));
        check("lsu_ready", 32'(lsu_res_ready_o), 32'(space));
        check("fpu_ready", 32'(fpu_res_ready_o), 32'(space && !lv));
        l_acc = lv && space;
        f_acc = fv && space && !lv;
        if (rst) begin
            sb.delete();
            fpr_exp.delete();
            mflags = 5'd0;
        end else begin
            if (l_acc || f_acc) begin
                e.id   = l_acc ? lt.id : ft.id;
                e.data = l_acc ? ld : fd;
                e.rd   = l_acc ? lt.addr : ft.addr;
                e.we   = l_acc ? !lt.rd_is_fp : !ft.rd_is_fp;
                sb.push_back(e);
                if (!e.we) begin
                    f.addr = e.rd;
                    f.data = e.data;
                    fpr_exp.push_back(f);
                end
            end
`ifdef FPU_SS_FFLAGS_ACC_EN
            if (f_acc) mflags = (clr ? 5'd0 : mflags) | st;
            else if (clr) mflags = 5'd0;
`endif
        end
    endtask

    task automatic idle(input int n, input logic xr);
        logic a, b;
        for (int i = 0; i < n; i++) drive(1'b0, '0, 32'd0, 1'b0, '0, 32'd0, 5'd0, 1'b0, xr, 1'b0, a, b);
    endtask

    task automatic fpu_push(input fpu_tag_t t, input logic [31:0] d, input logic [4:0] st,
                            input logic clr, input logic xr, output logic acc);
        logic a;
        drive(1'b0, '0, 32'd0, 1'b1, t, d, st, clr, xr, 1'b0, a, acc);
    endtask

    initial begin
        logic la, fa;
        int   k;
        logic [9:0] rt;
        fpu_tag_t   t1, t2;

        drive(1'b0, '0, 32'd0, 1'b0, '0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, la, fa);
        drive(1'b0, '0, 32'd0, 1'b0, '0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, la, fa);
        idle(2, 1'b1);

        // Single FP-destination FPU result.
        fpu_push(mk_tag(5'd3, 1'b1, 4'd5), 32'h3F80_0000, 5'd0, 1'b0, 1'b1, fa);
        check("single_accept", 32'(fa), 32'd1);
        idle(3, 1'b1);

        // LSU and FPU together: LSU first, FPU held until taken.
        drive(1'b1, mk_tag(5'd1, 1'b0, 4'd1), 32'h0000_1111, 1'b1, mk_tag(5'd2, 1'b0, 4'd2),
              32'h0000_2222, 5'd0, 1'b0, 1'b1, 1'b0, la, fa);
        fpu_push(mk_tag(5'd2, 1'b0, 4'd2), 32'h0000_2222, 5'd0, 1'b0, 1'b1, fa);
        idle(3, 1'b1);

        // Stall the consumer, offer DEPTH+1 results, then release with the push on the full+pop cycle.
        k = 0;
        for (int c = 0; c < 7; c++) begin
            fpu_push(mk_tag(5'(k), 1'b0, 4'(8 + k)), 32'hA000_0000 + 32'(k), 5'd0, 1'b0, 1'b0, fa);
            if (fa) k++;
        end
        check("full_accepts", 32'(k), 32'(DEPTH));
        for (int c = 0; c < 10 && k < DEPTH + 1; c++) begin
            fpu_push(mk_tag(5'(k), 1'b0, 4'(8 + k)), 32'hA000_0000 + 32'(k), 5'd0, 1'b0, 1'b1, fa);
            if (fa) k++;
        end
        idle(6, 1'b1);

        // Integer destination.
        fpu_push(mk_tag(5'd10, 1'b0, 4'd7), 32'h0000_0001, 5'd0, 1'b0, 1'b1, fa);
        idle(3, 1'b1);

        // Flag accumulation and clear-with-accept.
        fpu_push(mk_tag(5'd4, 1'b1, 4'd3), 32'd4, 5'h01, 1'b0, 1'b1, fa);
        fpu_push(mk_tag(5'd5, 1'b1, 4'd4), 32'd5, 5'h10, 1'b0, 1'b1, fa);
        idle(1, 1'b1);
        fpu_push(mk_tag(5'd6, 1'b1, 4'd6), 32'd6, 5'h04, 1'b1, 1'b1, fa);
        idle(2, 1'b1);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            rt = 10'($urandom); t1 = rt;
            rt = 10'($urandom); t2 = rt;
            drive($urandom_range(0, 3) == 0, t1, $urandom, $urandom_range(0, 1) == 1, t2, $urandom,
                  5'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 1'b0, la, fa);
        end
        idle(6, 1'b1);

        // Reset with three results pending and flags set.
        for (int c = 0; c < 3; c++) fpu_push(mk_tag(5'(c), 1'b1, 4'(c)), 32'(c), 5'h1F, 1'b0, 1'b0, fa);
        drive(1'b1, mk_tag(5'd9, 1'b1, 4'd9), 32'd9, 1'b1, '0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1, la, fa);
        idle(2, 1'b1);

        for (int c = 0; c < 300; c++) begin
            rt = 10'($urandom); t1 = rt;
            rt = 10'($urandom); t2 = rt;
            drive($urandom_range(0, 2) == 0, t1, $urandom, $urandom_range(0, 1) == 1, t2, $urandom,
                  5'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, 1'b0, la, fa);
        end
        idle(8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
